// File: rtl/lfsr_prbs_lock_check.sv
// Self-synchronising PRBS receive checker: feed-forward LFSR descrambler plus FILL/HUNT/LOCKED tracking.
// Define LFSR_PRBS_CHECK_BIT_COUNT_EN to accumulate errored bits instead of errored words.
module lfsr_prbs_lock_check #(
    parameter int                    LFSR_WIDTH   = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
    parameter string                 LFSR_CONFIG  = "FIBONACCI",
    parameter bit                    REVERSE      = 1'b0,
    parameter bit                    INVERT       = 1'b1,
    parameter int                    DATA_WIDTH   = 64,
    parameter string                 STYLE        = "AUTO",
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 8,
    parameter int                    COUNT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_in_valid,
    input  logic                   error_count_clear,
    output logic                   word_error,
    output logic                   locked,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int FILL_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int POP_W      = $clog2(DATA_WIDTH + 1);
    localparam int SUM_W      = ((COUNT_WIDTH > POP_W) ? COUNT_WIDTH : POP_W) + 1;

    typedef enum logic [1:0] {FILL = 2'd0, HUNT = 2'd1, LOCKED = 2'd2} state_t;

    if (LFSR_CONFIG != "FIBONACCI") begin : g_config_check
        $error("lfsr_prbs_lock_check: only the FIBONACCI LFSR configuration is implemented");
    end
    if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_style_check
        $error("lfsr_prbs_lock_check: STYLE must be AUTO, LOOP or REDUCTION");
    end

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    // One word through a feed-forward Fibonacci LFSR, first-shifted bit at the MSB.
    // The received bit (not the feedback) is shifted into the state, which is what makes it self-synchronising.
    function automatic logic [LFSR_WIDTH+DATA_WIDTH-1:0] lfsr_ff_step(
        input logic [LFSR_WIDTH-1:0] state_in,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [LFSR_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] o;
        logic                  fb;
        s = state_in;
        o = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = s[LFSR_WIDTH-1] ^ data[i];
            for (int j = 1; j < LFSR_WIDTH; j++) begin
                if (LFSR_POLY[j]) fb = fb ^ s[j-1];
            end
            o = {o[DATA_WIDTH-2:0], fb};
            s = {s[LFSR_WIDTH-2:0], data[i]};
        end
        return {s, o};
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_add(
        input logic [COUNT_WIDTH-1:0] a,
        input logic [POP_W-1:0]       b
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'({COUNT_WIDTH{1'b1}})) return '1;
        return sum[COUNT_WIDTH-1:0];
    endfunction

    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic [LFSR_WIDTH-1:0] lfsr_state_next;
    logic [DATA_WIDTH-1:0] data_ord;
    logic [DATA_WIDTH-1:0] lfsr_out;
    logic [DATA_WIDTH-1:0] err_vec;
    logic [DATA_WIDTH-1:0] err_vec_p1;
    logic                  vld_p1;
    logic                  bad_p1;
    logic [POP_W-1:0]      err_incr;

    always_comb begin
        data_ord = REVERSE ? bit_rev(data_in) : data_in;
        {lfsr_state_next, lfsr_out} = lfsr_ff_step(lfsr_state, data_ord);
        if (REVERSE) lfsr_out = bit_rev(lfsr_out);
        err_vec = lfsr_out ^ {DATA_WIDTH{INVERT}};
    end

    // Stage 1: descrambler state advance and error vector capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_state <= '0;
            err_vec_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= data_in_valid;
            if (data_in_valid) begin
                lfsr_state <= lfsr_state_next;
                err_vec_p1 <= err_vec;
            end
        end
    end

    assign bad_p1 = |err_vec_p1;

`ifdef LFSR_PRBS_CHECK_BIT_COUNT_EN
    logic [POP_W-1:0] pop_p1;

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_WIDTH; i++) n = n + POP_W'(v[i]);
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_p1 <= '0;
        end else if (data_in_valid) begin
            pop_p1 <= popcount(err_vec);
        end
    end

    assign err_incr = pop_p1;
`else
    assign err_incr = POP_W'(1);
`endif

    state_t                 state, state_next;
    logic [FILL_W-1:0]      fill_cnt, fill_cnt_next;
    logic [7:0]             good_cnt, good_cnt_next;
    logic [7:0]             bad_cnt, bad_cnt_next;
    logic                   word_error_next;
    logic                   count_inc;
    logic [COUNT_WIDTH-1:0] count_base;
    logic [COUNT_WIDTH-1:0] error_count_next;

    always_comb begin
        state_next      = state;
        fill_cnt_next   = fill_cnt;
        good_cnt_next   = good_cnt;
        bad_cnt_next    = bad_cnt;
        word_error_next = 1'b0;
        count_inc       = 1'b0;
        if (vld_p1) begin
            unique case (state)
                FILL: begin
                    if (fill_cnt == FILL_W'(FILL_WORDS - 1)) begin
                        state_next    = HUNT;
                        fill_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt + FILL_W'(1);
                    end
                end
                HUNT: begin
                    word_error_next = bad_p1;
                    if (bad_p1) begin
                        good_cnt_next = '0;
                    end else if (good_cnt == 8'(LOCK_COUNT - 1)) begin
                        state_next    = LOCKED;
                        good_cnt_next = '0;
                    end else begin
                        good_cnt_next = good_cnt + 8'd1;
                    end
                end
                LOCKED: begin
                    word_error_next = bad_p1;
                    if (bad_p1) begin
                        count_inc = 1'b1;
                        if (bad_cnt == 8'(UNLOCK_COUNT - 1)) begin
                            state_next   = HUNT;
                            bad_cnt_next = '0;
                        end else begin
                            bad_cnt_next = bad_cnt + 8'd1;
                        end
                    end else begin
                        bad_cnt_next = '0;
                    end
                end
                default: state_next = FILL;
            endcase
        end
        // Clear takes effect before the increment so a coincident error is not lost.
        count_base       = error_count_clear ? '0 : error_count;
        error_count_next = count_inc ? sat_add(count_base, err_incr) : count_base;
    end

    // Stage 2: lock state machine, counters and word_error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            word_error  <= 1'b0;
            error_count <= '0;
        end else begin
            state       <= state_next;
            fill_cnt    <= fill_cnt_next;
            good_cnt    <= good_cnt_next;
            bad_cnt     <= bad_cnt_next;
            word_error  <= word_error_next;
            error_count <= error_count_next;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_lfsr_prbs_lock_check.sv
// Scoreboard bench for lfsr_prbs_lock_check: default-width and COUNT_WIDTH=4 instances share one stimulus.
`timescale 1ns/1ps
module tb_lfsr_prbs_lock_check;

`ifdef LFSR_PRBS_CHECK_BIT_COUNT_EN
    localparam bit BITCNT    = 1'b1;
    localparam int FLIP_INCR = 3;
`else
    localparam bit BITCNT    = 1'b0;
    localparam int FLIP_INCR = 1;
`endif
    localparam logic [63:0] FLIP_MASK = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic        error_count_clear = 1'b0;
    logic        word_error, locked, word_error4, locked4;
    logic [31:0] error_count;
    logic [3:0]  error_count4;

    always #5 clk = ~clk;

    lfsr_prbs_lock_check dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .error_count_clear(error_count_clear), .word_error(word_error),
        .locked(locked), .error_count(error_count)
    );

    lfsr_prbs_lock_check #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .error_count_clear(error_count_clear), .word_error(word_error4),
        .locked(locked4), .error_count(error_count4)
    );

    typedef struct packed {
        logic        we;
        logic        lk;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;
    int   lock_word = -1;
    int   we_pulses = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmit side: Fibonacci PRBS31 generator, emitted inverted, first bit at the MSB.
    logic [30:0] gen = 31'h1;

    task automatic gen_word(output logic [63:0] w);
        logic b;
        for (int i = 63; i >= 0; i--) begin
            b   = gen[30] ^ gen[27];
            gen = {gen[29:0], b};
            w[i] = ~b;
        end
    endtask

    // Receive-side expectation: an inverted PRBS31 bit r[k] satisfies r[k]^r[k-28]^r[k-31] == 1.
    logic [30:0] rx_prev = '0;

    task automatic rx_eval(input logic [63:0] d, output bit bad, output int pop);
        logic [94:0] b;
        logic [63:0] e;
        b       = {rx_prev, d};
        e       = ~(b[63:0] ^ b[91:28] ^ b[94:31]);
        rx_prev = d[30:0];
        bad     = |e;
        pop     = $countones(e);
    endtask

    int     m_state = 0;
    int     m_fill = 0, m_good = 0, m_bad = 0;
    longint m_cnt = 0;
    int     m_cnt4 = 0;
    bit     pend_v = 0, pend_bad = 0;
    int     pend_pop = 0;

    task automatic model_step(input bit clr);
        bit we;
        int inc;
        exp_t e;
        if (clr) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end
        if (pend_v) begin
            we = 1'b0;
            case (m_state)
                0: begin
                    m_fill++;
                    if (m_fill == 1) begin m_state = 1; m_fill = 0; end
                end
                1: begin
                    we = pend_bad;
                    if (pend_bad) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == 16) begin m_state = 2; m_good = 0; end
                    end
                end
                default: begin
                    we = pend_bad;
                    if (pend_bad) begin
                        inc    = BITCNT ? pend_pop : 1;
                        m_cnt  = (m_cnt + inc > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + inc;
                        m_cnt4 = (m_cnt4 + inc > 15) ? 15 : m_cnt4 + inc;
                        m_bad++;
                        if (m_bad == 8) begin m_state = 1; m_bad = 0; end
                    end else m_bad = 0;
                end
            endcase
            e.we = we; e.lk = (m_state == 2); e.cnt = m_cnt[31:0]; e.cnt4 = 4'(m_cnt4);
            sb_q.push_back(e);
        end
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit clr);
        bit b;
        int p;
        data_in_valid     = v;
        data_in           = d;
        error_count_clear = clr;
        model_step(clr);
        pend_v = v;
        if (v) begin
            rx_eval(d, b, p);
            pend_bad = b;
            pend_pop = p;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_prbs(input logic [63:0] flip);
        logic [63:0] w;
        gen_word(w);
        drive(1'b1, w ^ flip, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_error_count", 64'(error_count), 64'd0);
        check("rst_word_error", 64'(word_error), 64'd0);
        check("rst_error_count4", 64'(error_count4), 64'd0);
        sb_q.delete();
        pend_v = 0; m_state = 0; m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_cnt4 = 0;
        rx_prev = '0; wcount = 0; lock_word = -1; we_pulses = 0;
        data_in_valid = 1'b0; data_in = '0; error_count_clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Output alignment: a word accepted at edge N is reflected on the outputs after edge N+1.
    logic [1:0] tb_v;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_v <= '0;
        else     tb_v <= {tb_v[0], data_in_valid};
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tb_v[1]) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: output word with no expectation at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("word", {24'd0, word_error, locked, word_error4, locked4, error_count, error_count4},
                          {24'd0, e.we, e.lk, e.we, e.lk, e.cnt, e.cnt4});
                    wcount++;
                    if (locked && lock_word < 0) lock_word = wcount;
                    if (word_error) we_pulses++;
                end
            end else begin
                check("idle_word_error", 64'(word_error), 64'd0);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, nvalid;
        do_reset();

        for (int i = 0; i < 1000; i++) drive_prbs('0);
        idle(2);
        check("clean_lock_word", 64'(lock_word), 64'd17);
        check("clean_error_count", 64'(error_count), 64'd0);
        check("clean_word_error_pulses", 64'(we_pulses), 64'd0);

        we0 = we_pulses;
        drive_prbs(FLIP_MASK);
        for (int i = 0; i < 5; i++) drive_prbs('0);
        idle(2);
        check("flip_pulses", 64'(we_pulses - we0), 64'd1);
        check("flip_error_count", 64'(error_count), 64'(FLIP_INCR));
        check("flip_locked", 64'(locked), 64'd1);

        drive(1'b0, '0, 1'b1);
        idle(1);
        check("clear_alone", 64'(error_count), 64'd0);
        for (int i = 0; i < 8; i++) drive(1'b1, '0, 1'b0);
        idle(2);
        check("lockloss_locked", 64'(locked), 64'd0);
        if (!BITCNT) check("lockloss_error_count", 64'(error_count), 64'd8);
        for (int i = 0; i < 17; i++) drive_prbs('0);
        idle(2);
        check("relock_locked", 64'(locked), 64'd1);

        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive_prbs(FLIP_MASK);
            drive_prbs('0);
            drive_prbs('0);
        end
        idle(2);
        check("sat_error_count4", 64'(error_count4), 64'd15);
        check("sat_error_count", 64'(error_count), 64'(20 * FLIP_INCR));
        check("sat_locked", 64'(locked), 64'd1);

        drive_prbs(FLIP_MASK);
        gen_word(data_in);
        drive(1'b1, data_in, 1'b1);
        idle(2);
        check("clear_with_bad", 64'(error_count), 64'(FLIP_INCR));
        check("clear_with_bad4", 64'(error_count4), 64'(FLIP_INCR));

        do_reset();
        nvalid = 0;
        for (int i = 0; i < 400 && nvalid < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                drive_prbs('0);
                nvalid++;
            end else idle(1);
        end
        idle(2);
        check("gapped_lock_word", 64'(lock_word), 64'd17);
        for (int i = 0; i < 3; i++) drive_prbs('0);
        do_reset();
        for (int i = 0; i < 20; i++) drive_prbs('0);
        idle(2);
        check("restart_lock_word", 64'(lock_word), 64'd17);
        check("restart_locked", 64'(locked), 64'd1);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
